muldiv_ctrl: RTL

Iterative multiply/divide sequencer for the pipelined MIPS core. It executes MULT, MULTU, DIV and DIVU over multiple cycles, owns the HI/LO registers, and applies MTHI/MTLO writes. It generates the pipeline stall that holds back MFHI/MFLO and new mul/div issue while an operation is in flight. It sits beside the EX-stage ALU and reuses the team's ripple `adder_32bit` for every add/subtract step.

---
 rtl/muldiv_ctrl_pkg.sv | 30 +++
 rtl/adder_32bit.sv | 26 ++
 rtl/muldiv_ctrl.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/muldiv_ctrl_pkg.sv
// Shared encodings for the iterative multiply/divide sequencer.
// Op and FSM state enums plus small op-decode helpers.
package muldiv_ctrl_pkg;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    FIX  = 2'b10
  } state_e;

  function automatic logic is_div(
    input logic [1:0] op
  );
    return op[1];
  endfunction

  function automatic logic is_sgn(
    input logic [1:0] op
  );
    return ~op[0];
  endfunction

endpackage

// File: rtl/adder_32bit.sv
// Ripple-carry 32-bit adder shared by the mul/div datapath.
// Ports: i_a, i_b, i_cin in; o_sum, o_cout out.
module adder_32bit (
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  input  logic        i_cin,
  output logic [31:0] o_sum,
  output logic        o_cout
);

  logic [32:0] w_c;

  always_comb begin
    w_c    = '0;
    o_sum  = '0;
    w_c[0] = i_cin;
    for (int i = 0; i < 32; i++) begin
      o_sum[i]  = i_a[i] ^ i_b[i] ^ w_c[i];
      w_c[i+1]  = (i_a[i] & i_b[i])
                | (w_c[i] & (i_a[i] ^ i_b[i]));
    end
  end

  assign o_cout = w_c[32];

endmodule

// File: rtl/muldiv_ctrl.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer owning HI/LO, with stall.
// Ports: clk, reset(n), start/op/srca/srcb issue, flush, rd_req,
//        hi_we/lo_we/wd MT writes; hi, lo, busy, done, stall out.
module muldiv_ctrl
  import muldiv_ctrl_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] srca,
  input  logic [WIDTH-1:0] srcb,
  input  logic             flush,
  input  logic             rd_req,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wd,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             stall
);

  state_e           r_state;
  state_e           w_next;
  logic [CNT_W-1:0] r_cnt;
  logic [1:0]       r_op;
  logic             r_sa;
  logic             r_sb;
  logic             r_dz;
  logic             r_done;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;

  logic             w_issue;
  logic             w_dz_in;
  logic             w_sa_in;
  logic             w_sb_in;
  logic [WIDTH-1:0] w_abs_a;
  logic [WIDTH-1:0] w_abs_b;

  assign w_issue = (r_state == IDLE) & start & ~flush;
  assign w_dz_in = is_div(op) & (srcb == '0);
  assign w_sa_in = is_sgn(op) & srca[WIDTH-1];
  assign w_sb_in = is_sgn(op) & srcb[WIDTH-1];
  assign w_abs_a = w_sa_in ? -srca : srca;
  assign w_abs_b = w_sb_in ? -srcb : srcb;

  // Divide shifts {rem,quo} left before the trial subtract.
  logic [WIDTH-1:0] w_rem_s;
  logic [WIDTH-1:0] w_add_a;
  logic [WIDTH-1:0] w_add_b;
  logic             w_add_ci;
  logic [WIDTH-1:0] w_sum;
  logic             w_cout;

  assign w_rem_s  = {r_acc[WIDTH-2:0], r_q[WIDTH-1]};
  assign w_add_a  = is_div(r_op) ? w_rem_s : r_acc;
  assign w_add_b  = is_div(r_op) ? ~r_b : r_b;
  assign w_add_ci = is_div(r_op);

  adder_32bit u_add (
    .i_a    (w_add_a),
    .i_b    (w_add_b),
    .i_cin  (w_add_ci),
    .o_sum  (w_sum),
    .o_cout (w_cout)
  );

  // The bit shifted out of rem is the 33rd bit of the
  // partial remainder; if set, the subtract cannot borrow.
  logic             w_nb;
  logic [WIDTH-1:0] w_acc_n;
  logic [WIDTH-1:0] w_q_n;

  assign w_nb = w_cout | r_acc[WIDTH-1];

  always_comb begin
    w_acc_n = r_acc;
    w_q_n   = r_q;
    if (is_div(r_op)) begin
      w_acc_n = w_nb ? w_sum : w_rem_s;
      w_q_n   = {r_q[WIDTH-2:0], w_nb};
    end else if (r_q[0]) begin
      {w_acc_n, w_q_n} = {w_cout, w_sum, r_q[WIDTH-1:1]};
    end else begin
      {w_acc_n, w_q_n} = {1'b0, r_acc, r_q[WIDTH-1:1]};
    end
  end

  logic [2*WIDTH-1:0] w_prod;
  logic [2*WIDTH-1:0] w_prod_f;
  logic [WIDTH-1:0]   w_quo_f;
  logic [WIDTH-1:0]   w_rem_f;

  assign w_prod   = {r_acc, r_q};
  assign w_prod_f = (r_sa ^ r_sb) ? -w_prod : w_prod;
  assign w_quo_f  = (r_sa ^ r_sb) ? -r_q : r_q;
  assign w_rem_f  = r_sa ? -r_acc : r_acc;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: if (w_issue) w_next = w_dz_in ? FIX : RUN;
      RUN: begin
        if (flush)              w_next = IDLE;
        else if (r_cnt == '0)   w_next = FIX;
      end
      FIX:     w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt  <= '0;
      r_op   <= '0;
      r_sa   <= 1'b0;
      r_sb   <= 1'b0;
      r_dz   <= 1'b0;
      r_done <= 1'b0;
      r_acc  <= '0;
      r_q    <= '0;
      r_b    <= '0;
      r_hi   <= '0;
      r_lo   <= '0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (w_issue) begin
            r_op  <= op;
            r_sa  <= w_sa_in;
            r_sb  <= w_sb_in;
            r_dz  <= w_dz_in;
            r_acc <= w_dz_in ? srca : '0;
            r_q   <= w_abs_a;
            r_b   <= w_abs_b;
            r_cnt <= CNT_W'(WIDTH-1);
          end else if (!start) begin
            if (hi_we) r_hi <= wd;
            if (lo_we) r_lo <= wd;
          end
        end
        RUN: begin
          if (!flush) begin
            r_acc <= w_acc_n;
            r_q   <= w_q_n;
            r_cnt <= r_cnt - 1'b1;
          end
        end
        FIX: begin
          if (!flush) begin
            r_done <= 1'b1;
            if (r_dz) begin
              r_hi <= r_acc;
              r_lo <= '1;
            end else if (is_div(r_op)) begin
              r_hi <= w_rem_f;
              r_lo <= w_quo_f;
            end else begin
              r_hi <= w_prod_f[2*WIDTH-1:WIDTH];
              r_lo <= w_prod_f[WIDTH-1:0];
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign hi    = r_hi;
  assign lo    = r_lo;
  assign done  = r_done;
  assign busy  = (r_state != IDLE);
  assign stall = busy & (rd_req | start | hi_we | lo_we);

endmodule
